// File: rtl/loader_pkg.sv
// Shared types for the boot-time program loader: FSM state encoding and
// the 2-bit error codes reported on err.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    RUN,
    ERR
  } loader_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses a length / payload / XOR-checksum byte frame, writes the
// payload into program memory from address 0 and releases the CPU on success.
module prog_loader
  import loader_pkg::*;
#(
  parameter int SIZE = 256,
  parameter int AW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          write,
  output logic [AW-1:0] writeaddr,
  output logic [7:0]    writevalue,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err
);

  localparam logic [15:0] SIZE_W = 16'(SIZE);

  loader_state_t state;
  logic [7:0]    len_hi;
  logic [AW:0]   len_r;
  logic [AW:0]   cnt;
  logic [7:0]    csum;
  logic          rdy;

  logic          acc;
  logic [15:0]   len_full;
  logic [AW:0]   cnt_nxt;

  // rdy is the registered "receiving" flag; load blanks it in its own cycle
  // so an aborting pulse can never also consume a byte.
  assign in_ready = rdy & ~load;
  assign acc      = in_valid & in_ready;
  assign len_full = {len_hi, in_data};
  assign cnt_nxt  = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      len_hi     <= '0;
      len_r      <= '0;
      cnt        <= '0;
      csum       <= '0;
      rdy        <= 1'b0;
      write      <= 1'b0;
      writeaddr  <= '0;
      writevalue <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_NONE;
    end else begin
      write <= 1'b0;
      if (load) begin
        state   <= LEN_HI;
        cnt     <= '0;
        csum    <= '0;
        rdy     <= 1'b1;
        busy    <= 1'b1;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
        err     <= ERR_NONE;
      end else begin
        case (state)
          LEN_HI: begin
            if (acc) begin
              len_hi <= in_data;
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (acc) begin
              len_r <= len_full[AW:0];
              if (len_full > SIZE_W) begin
                state <= ERR;
                err   <= ERR_LEN;
                rdy   <= 1'b0;
                busy  <= 1'b0;
              end else if (len_full == 16'd0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (acc) begin
              write      <= 1'b1;
              writeaddr  <= cnt[AW-1:0];
              writevalue <= in_data;
              csum       <= csum ^ in_data;
              cnt        <= cnt_nxt;
              if (cnt_nxt == len_r) state <= CSUM;
            end
          end
          CSUM: begin
            if (acc) begin
              rdy  <= 1'b0;
              busy <= 1'b0;
              if (in_data == csum) begin
                state   <= RUN;
                cpu_rst <= 1'b0;
                done    <= 1'b1;
              end else begin
                state <= ERR;
                err   <= ERR_CSUM;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a frame-level reference model and
// per-cycle output comparison.
module tb_prog_loader;

  localparam int SIZE = 256;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          write;
  logic [AW-1:0] writeaddr;
  logic [7:0]    writevalue;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic [1:0]    err;

  prog_loader #(.SIZE(SIZE), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .write(write), .writeaddr(writeaddr),
    .writevalue(writevalue), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame seen since the last load, interpreted as a whole.
  logic [7:0] frame[$];
  bit         active = 0;
  bit         m_ready = 0, m_busy = 0, m_done = 0, m_cpu_rst = 1, m_write = 0;
  logic [1:0] m_err = 2'b00;
  logic [7:0] m_waddr = 8'h00, m_wval = 8'h00;

  function automatic int flen();
    return {frame[0], frame[1]};
  endfunction

  function automatic bit finished();
    if (frame.size() < 2) return 0;
    return (flen() > SIZE) || (frame.size() == flen() + 3);
  endfunction

  always @(posedge clk) begin
    int p;
    logic [7:0] x;
    m_write = 0;
    if (!rst) begin
      active = 0;
      frame.delete();
      m_waddr = 8'h00;
      m_wval = 8'h00;
    end else if (load) begin
      active = 1;
      frame.delete();
    end else if (in_valid && m_ready) begin
      p = frame.size();
      if (p >= 2 && p < flen() + 2) begin
        m_write = 1;
        m_waddr = 8'(p - 2);
        m_wval  = in_data;
      end
      frame.push_back(in_data);
    end
    m_ready = active && !finished();
    m_busy = m_ready;
    m_done = 0;
    m_err = 2'b00;
    if (active && finished()) begin
      if (flen() > SIZE) m_err = 2'b01;
      else begin
        x = 8'h00;
        for (int i = 2; i < flen() + 2; i++) x ^= frame[i];
        if (x == frame[flen() + 2]) m_done = 1;
        else m_err = 2'b10;
      end
    end
    m_cpu_rst = !m_done;
  end

  bit armed = 0;
  int wr_count = 0;
  logic [7:0] cap_mem [0:255];
  logic [7:0] last_addr = 8'h00;

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, m_ready && !load);
      chk("write", write, m_write);
      chk("writeaddr", writeaddr, m_waddr);
      chk("writevalue", writevalue, m_wval);
      chk("cpu_rst", cpu_rst, m_cpu_rst);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
    end
    if (write === 1'b1) begin
      cap_mem[writeaddr] = writevalue;
      last_addr = writeaddr;
      wr_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) step();
  endtask

  logic [7:0] txq[$];

  task automatic send_q(input int gap);
    foreach (txq[i]) send(txq[i], gap);
    txq.delete();
  endtask

  initial begin
    logic [7:0] x;
    step(); step();
    armed = 1;
    chk("reset_cpu_rst", cpu_rst, 1'b1);
    chk("reset_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    step();

    // good frame, one byte per cycle
    pulse_load();
    wr_count = 0;
    txq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h70};
    send_q(0);
    step();
    chk("f1_mem0", cap_mem[0], 8'h12);
    chk("f1_mem1", cap_mem[1], 8'h34);
    chk("f1_mem2", cap_mem[2], 8'h56);
    chk("f1_writes", wr_count, 3);
    chk("f1_done", done, 1'b1);
    chk("f1_cpu_rst", cpu_rst, 1'b0);

    // bad checksum
    pulse_load();
    wr_count = 0;
    txq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h71};
    send_q(0);
    step();
    chk("f2_writes", wr_count, 3);
    chk("f2_err", err, 2'b10);
    chk("f2_cpu_rst", cpu_rst, 1'b1);

    // length 257 rejected
    pulse_load();
    wr_count = 0;
    txq = '{8'h01, 8'h01, 8'hAA};
    send_q(0);
    step();
    chk("f3_err", err, 2'b01);
    chk("f3_writes", wr_count, 0);
    chk("f3_in_ready", in_ready, 1'b0);

    // empty payload, good then bad checksum
    pulse_load();
    txq = '{8'h00, 8'h00, 8'h00};
    send_q(0);
    step();
    chk("f4_done", done, 1'b1);
    pulse_load();
    txq = '{8'h00, 8'h00, 8'h01};
    send_q(0);
    step();
    chk("f5_err", err, 2'b10);

    // load aborts mid-payload; the byte offered with it is dropped
    pulse_load();
    wr_count = 0;
    txq = '{8'h00, 8'h04, 8'hC1, 8'hC2};
    send_q(0);
    load = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    step();
    load = 1'b0; in_valid = 1'b0;
    step();
    chk("abort_writes", wr_count, 2);
    chk("abort_busy", busy, 1'b1);
    txq = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'h11};
    send_q(0);
    step();
    chk("f6_mem0", cap_mem[0], 8'hAA);
    chk("f6_mem1", cap_mem[1], 8'hBB);
    chk("f6_mem2", cap_mem[2], 8'hC2 ^ 8'h00 ^ 8'h00 ^ 8'h00 ^ 8'h94);
    chk("f6_done", done, 1'b1);

    // full-size frame with gapped valid
    pulse_load();
    wr_count = 0;
    x = 8'h00;
    txq.push_back(8'h01);
    txq.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      txq.push_back(8'(i) ^ 8'h5A);
      x ^= 8'(i) ^ 8'h5A;
    end
    txq.push_back(x);
    send_q(2);
    chk("f7_writes", wr_count, 256);
    chk("f7_last_addr", last_addr, 8'hFF);
    chk("f7_mem_ff", cap_mem[255], 8'hA5);
    chk("f7_done", done, 1'b1);

    // reset mid-frame
    pulse_load();
    txq = '{8'h00, 8'h05, 8'h01, 8'h02};
    send_q(0);
    rst = 1'b0;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_writeaddr", writeaddr, 8'h00);
    rst = 1'b1;
    step(); step();

    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
